// File: rtl/fu_jump_pipe.sv
// Pipelined branch/jump unit: resolves target, link, taken and misalignment for one op per
// cycle, then carries the tagged result through LATENCY stages toward write-back.
module fu_jump_pipe #(
  parameter int XLEN    = 32,
  parameter int LATENCY = 2,
  parameter int TAG_W   = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_op,
  input  logic [2:0]       cmp_ctrl,
  input  logic [XLEN-1:0]  rs1_data,
  input  logic [XLEN-1:0]  rs2_data,
  input  logic [XLEN-1:0]  imm,
  input  logic [XLEN-1:0]  pc,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [TAG_W-1:0] out_tag,
  output logic [XLEN-1:0]  pc_jump,
  output logic [XLEN-1:0]  pc_wb,
  output logic             taken,
  output logic             misalign,
  output logic             busy
);

  localparam int PW = TAG_W + 2 * XLEN + 2;

  localparam logic [1:0] OP_BRANCH = 2'b00;
  localparam logic [1:0] OP_JAL    = 2'b01;
  localparam logic [1:0] OP_JALR   = 2'b10;

  logic                  stall;
  logic                  accept;
  logic                  cmp_next;
  logic                  taken_next;
  logic                  misalign_next;
  logic [XLEN-1:0]       jalr_sum;
  logic [XLEN-1:0]       jump_next;
  logic [XLEN-1:0]       link_next;
  logic [PW-1:0]         result_next;

  logic [LATENCY-1:0]         valid_reg;
  logic [LATENCY-1:0]         valid_next;
  logic [LATENCY-1:0][PW-1:0] payload_reg;
  logic [LATENCY-1:0][PW-1:0] payload_next;

  assign stall    = valid_reg[LATENCY-1] & ~out_ready;
  assign in_ready = ~stall & ~flush;
  assign accept   = in_valid & in_ready;
  assign busy     = |valid_reg;

  always_comb begin
    cmp_next = 1'b0;
    case (cmp_ctrl)
      3'b000:  cmp_next = (rs1_data == rs2_data);
      3'b001:  cmp_next = (rs1_data != rs2_data);
      3'b100:  cmp_next = ($signed(rs1_data) <  $signed(rs2_data));
      3'b101:  cmp_next = ($signed(rs1_data) >= $signed(rs2_data));
      3'b110:  cmp_next = (rs1_data <  rs2_data);
      3'b111:  cmp_next = (rs1_data >= rs2_data);
      default: cmp_next = 1'b0;
    endcase
  end

  always_comb begin
    taken_next = 1'b0;
    case (in_op)
      OP_BRANCH: taken_next = cmp_next;
      OP_JAL:    taken_next = 1'b1;
      OP_JALR:   taken_next = 1'b1;
      default:   taken_next = 1'b0;
    endcase
  end

  // JALR drops bit 0 of the register-relative target; everything else is PC-relative.
  assign jalr_sum      = rs1_data + imm;
  assign jump_next     = (in_op == OP_JALR) ? {jalr_sum[XLEN-1:1], 1'b0} : (pc + imm);
  assign link_next     = pc + XLEN'(4);
  assign misalign_next = taken_next & jump_next[1];
  assign result_next   = {in_tag, jump_next, link_next, taken_next, misalign_next};

  genvar gi;
  generate
    for (gi = 0; gi < LATENCY; gi++) begin : g_stage_in
      if (gi == 0) begin : g_head
        assign valid_next[gi]   = accept;
        assign payload_next[gi] = result_next;
      end else begin : g_tail
        assign valid_next[gi]   = valid_reg[gi-1];
        assign payload_next[gi] = payload_reg[gi-1];
      end
    end
  endgenerate

  // A stall freezes every stage, so bubbles are never squeezed out behind a blocked head.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_reg   <= '0;
      payload_reg <= '0;
    end else if (flush) begin
      valid_reg <= '0;
    end else if (!stall) begin
      valid_reg   <= valid_next;
      payload_reg <= payload_next;
    end
  end

  assign out_valid = valid_reg[LATENCY-1];
  assign {out_tag, pc_jump, pc_wb, taken, misalign} = payload_reg[LATENCY-1];

endmodule

// File: tb/tb_fu_jump_pipe.sv
// Bench for fu_jump_pipe: LATENCY 1, 2 and 4 builds share one stimulus stream, each tracked
// by its own queue-of-ops reference model, plus directed value checks on the 2-stage build.
module tb_fu_jump_pipe;

  localparam int NI = 3;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, out_ready;
  logic [1:0]  in_op;
  logic [2:0]  cmp_ctrl;
  logic [31:0] rs1_data, rs2_data, imm, pc;
  logic [4:0]  in_tag;

  logic        in_ready_w  [NI];
  logic        out_valid_w [NI];
  logic        taken_w     [NI];
  logic        misalign_w  [NI];
  logic        busy_w      [NI];
  logic [4:0]  out_tag_w   [NI];
  logic [31:0] pc_jump_w   [NI];
  logic [31:0] pc_wb_w     [NI];

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic [31:0] pc_jump;
    logic [31:0] pc_wb;
    logic        taken;
    logic        misalign;
    logic [4:0]  tag;
    int          pos;
  } ent_t;

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Architectural meaning of one op, straight from the ISA rules.
  function automatic ent_t ref_op(input logic [1:0] op, input logic [2:0] f3,
                                  input logic [31:0] a, input logic [31:0] b,
                                  input logic [31:0] im, input logic [31:0] p,
                                  input logic [4:0] tg);
    ent_t e;
    logic c;
    case (f3)
      3'd0:    c = (a == b);
      3'd1:    c = (a != b);
      3'd4:    c = ($signed(a) <  $signed(b));
      3'd5:    c = ($signed(a) >= $signed(b));
      3'd6:    c = (a <  b);
      3'd7:    c = (a >= b);
      default: c = 1'b0;
    endcase
    e.pc_wb    = p + 32'd4;
    e.pc_jump  = (op == 2'b10) ? ((a + im) & 32'hFFFF_FFFE) : (p + im);
    e.taken    = (op == 2'b01 || op == 2'b10) ? 1'b1 : ((op == 2'b00) ? c : 1'b0);
    e.misalign = e.taken & e.pc_jump[1];
    e.tag      = tg;
    e.pos      = 0;
    return e;
  endfunction

  genvar gi;
  for (gi = 0; gi < NI; gi++) begin : g_dut
    localparam int LAT = (gi == 0) ? 1 : ((gi == 1) ? 2 : 4);
    ent_t q[$];

    fu_jump_pipe #(.XLEN(32), .LATENCY(LAT), .TAG_W(5)) u_dut (
      .clk(clk), .rst(rst), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready_w[gi]),
      .in_op(in_op), .cmp_ctrl(cmp_ctrl),
      .rs1_data(rs1_data), .rs2_data(rs2_data), .imm(imm), .pc(pc), .in_tag(in_tag),
      .out_valid(out_valid_w[gi]), .out_ready(out_ready), .out_tag(out_tag_w[gi]),
      .pc_jump(pc_jump_w[gi]), .pc_wb(pc_wb_w[gi]),
      .taken(taken_w[gi]), .misalign(misalign_w[gi]), .busy(busy_w[gi])
    );

    // Each op ages one position per unstalled edge; it is visible once it reaches LAT-1.
    always @(negedge clk) begin
      logic ev;
      logic st;
      ev = (q.size() > 0) && (q[0].pos == LAT - 1);
      st = ev && !out_ready;
      if (!rst) begin
        check($sformatf("L%0d out_valid", LAT), 32'(out_valid_w[gi]), 32'(ev));
        check($sformatf("L%0d busy", LAT), 32'(busy_w[gi]), 32'(q.size() > 0));
        check($sformatf("L%0d in_ready", LAT), 32'(in_ready_w[gi]), 32'(!st && !flush));
        if (ev) begin
          check($sformatf("L%0d pc_jump", LAT), pc_jump_w[gi], q[0].pc_jump);
          check($sformatf("L%0d pc_wb", LAT), pc_wb_w[gi], q[0].pc_wb);
          check($sformatf("L%0d taken", LAT), 32'(taken_w[gi]), 32'(q[0].taken));
          check($sformatf("L%0d misalign", LAT), 32'(misalign_w[gi]), 32'(q[0].misalign));
          check($sformatf("L%0d out_tag", LAT), 32'(out_tag_w[gi]), 32'(q[0].tag));
        end
      end
      if (rst || flush) begin
        q.delete();
      end else if (!st) begin
        if (ev) begin
          $display("L%0d result tag=%0d pc_jump=%h pc_wb=%h taken=%0d misalign=%0d",
                   LAT, q[0].tag, q[0].pc_jump, q[0].pc_wb, q[0].taken, q[0].misalign);
          void'(q.pop_front());
        end
        foreach (q[i]) q[i].pos = q[i].pos + 1;
        if (in_valid) q.push_back(ref_op(in_op, cmp_ctrl, rs1_data, rs2_data, imm, pc, in_tag));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [1:0] op, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] im, input logic [31:0] p,
                       input logic [4:0] tg);
    in_op = op; cmp_ctrl = f3; rs1_data = a; rs2_data = b; imm = im; pc = p; in_tag = tg;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
  endtask

  task automatic rand_op();
    in_op    = 2'($urandom_range(0, 3));
    cmp_ctrl = 3'($urandom_range(0, 7));
    rs1_data = $urandom;
    rs2_data = ($urandom_range(0, 3) == 0) ? rs1_data : $urandom;
    imm      = ($urandom_range(0, 1) == 0) ? $urandom : 32'($urandom_range(0, 31));
    pc       = $urandom & 32'hFFFF_FFFC;
    in_tag   = 5'($urandom_range(0, 31));
  endtask

  // Waits (bounded) until the 2-stage build presents a result; returns at a negedge.
  task automatic wait_l2(input string tag);
    bit seen;
    seen = 1'b0;
    for (int k = 0; k < 10 && !seen; k++) begin
      @(negedge clk);
      if (out_valid_w[1]) seen = 1'b1;
    end
    check({tag, " seen"}, 32'(seen), 32'd1);
  endtask

  task automatic check_reset(input string tag);
    for (int k = 0; k < NI; k++) begin
      check({tag, " out_valid"}, 32'(out_valid_w[k]), 32'd0);
      check({tag, " out_tag"}, 32'(out_tag_w[k]), 32'd0);
      check({tag, " pc_jump"}, pc_jump_w[k], 32'd0);
      check({tag, " pc_wb"}, pc_wb_w[k], 32'd0);
      check({tag, " taken"}, 32'(taken_w[k]), 32'd0);
      check({tag, " misalign"}, 32'(misalign_w[k]), 32'd0);
      check({tag, " busy"}, 32'(busy_w[k]), 32'd0);
      check({tag, " in_ready"}, 32'(in_ready_w[k]), 32'd1);
    end
  endtask

  initial begin
    logic [7:0] sweep_exp;
    sweep_exp = 8'b1001_0010;
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    in_op = '0; cmp_ctrl = '0; rs1_data = '0; rs2_data = '0; imm = '0; pc = '0; in_tag = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check_reset("reset");
    step();

    drive(2'b01, 3'd0, 32'd0, 32'd0, 32'h20, 32'h100, 5'd3);
    wait_l2("jal");
    check("jal pc_jump", pc_jump_w[1], 32'h120);
    check("jal pc_wb", pc_wb_w[1], 32'h104);
    check("jal taken", 32'(taken_w[1]), 32'd1);
    check("jal misalign", 32'(misalign_w[1]), 32'd0);
    check("jal tag", 32'(out_tag_w[1]), 32'd3);
    step();

    drive(2'b10, 3'd0, 32'h1003, 32'd0, 32'h4, 32'h200, 5'd4);
    wait_l2("jalr");
    check("jalr pc_jump", pc_jump_w[1], 32'h1006);
    check("jalr misalign", 32'(misalign_w[1]), 32'd1);
    step();

    drive(2'b01, 3'd0, 32'd0, 32'd0, 32'h8, 32'hFFFF_FFFC, 5'd5);
    wait_l2("wrap");
    check("wrap pc_wb", pc_wb_w[1], 32'h0);
    check("wrap pc_jump", pc_jump_w[1], 32'h4);
    step();

    for (int k = 0; k < 8; k++) begin
      drive(2'b00, 3'(k), 32'hFFFF_FFFF, 32'h1, 32'h40, 32'h300, 5'(k));
      wait_l2($sformatf("sweep%0d", k));
      check($sformatf("sweep%0d taken", k), 32'(taken_w[1]), 32'(sweep_exp[k]));
      step();
    end

    drive(2'b11, 3'd0, 32'd5, 32'd5, 32'h10, 32'h400, 5'd9);
    wait_l2("rsvd");
    check("rsvd taken", 32'(taken_w[1]), 32'd0);
    check("rsvd pc_jump", pc_jump_w[1], 32'h410);
    step();

    // Four back-to-back ops, then three stalled cycles with a fifth op waiting.
    for (int k = 0; k < 4; k++) begin
      rand_op();
      in_valid = 1'b1;
      step();
    end
    out_ready = 1'b0;
    rand_op();
    @(negedge clk);
    check("stall in_ready", 32'(in_ready_w[1]), 32'd0);
    step();
    repeat (2) step();
    out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    repeat (6) step();

    // Flush with ops in flight and a presented op, then a normal op right after.
    rand_op(); in_valid = 1'b1; step();
    rand_op(); step();
    rand_op(); flush = 1'b1; step();
    flush = 1'b0;
    drive(2'b01, 3'd0, 32'd0, 32'd0, 32'h8, 32'h500, 5'd17);
    check("flush busy", 32'(busy_w[2]), 32'd1);
    wait_l2("post-flush");
    check("post-flush tag", 32'(out_tag_w[1]), 32'd17);
    step();
    repeat (4) step();

    rand_op(); in_valid = 1'b1; step();
    rand_op(); step();
    in_valid = 1'b0; rst = 1'b1; step();
    rst = 1'b0;
    @(negedge clk);
    check_reset("mid reset");
    step();

    for (int c = 0; c < 600; c++) begin
      rand_op();
      in_valid  = ($urandom_range(0, 9) < 7);
      out_ready = ($urandom_range(0, 3) != 0);
      flush     = ($urandom_range(0, 39) == 0);
      rst       = ($urandom_range(0, 99) == 0);
      step();
    end
    rst = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    repeat (8) step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
